// File: rtl/chan_router_pkg.sv
// chan_router_pkg: shared mode encoding for the channel router
package chan_router_pkg;
  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_BCAST = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;
endpackage

// File: rtl/rr_find_next.sv
// rr_find_next: first set mask bit at or after start, wrapping modulo NCH
module rr_find_next #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] idx,
  output logic            found
);
  // scan offsets from farthest to nearest so the nearest hit is the one kept
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--)
      if (mask[(int'(start) + k) % NCH]) begin
        idx = SELW'((int'(start) + k) % NCH);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/chan_router.sv
// chan_router: registered N-channel router with addressed, broadcast, scan and clear writes
module chan_router
  import chan_router_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DW   = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  input  logic [SELW-1:0]   sel,
  input  logic [DW-1:0]     data,
  input  logic              wr,
  input  logic [1:0]        mode,
  output logic [NCH*DW-1:0] out,
  output logic [NCH-1:0]    out_vld,
  output logic [SELW-1:0]   ptr,
  output logic              err
);
  logic [NCH-1:0][DW-1:0] ch;
  logic [NCH-1:0]         sel_oh, wmask;
  logic [DW-1:0]          wval;
  logic [SELW-1:0]        ptr_n, idx;
  logic                   err_n, found;
  mode_t                  m;

  assign m = mode_t'(mode);
  assign out = ch;
  assign sel_oh = NCH'(1) << sel;

  rr_find_next #(.NCH(NCH), .SELW(SELW)) u_find (
    .mask(en),
    .start(ptr),
    .idx(idx),
    .found(found)
  );

  // decode this edge's write: which channels, what value, next pointer, reject
  always_comb begin
    wmask = '0;
    wval = data;
    err_n = 1'b0;
    ptr_n = ptr;
    if (wr)
      case (m)
        MODE_ADDR: begin
          wmask = sel_oh & en;
          err_n = ~|(sel_oh & en);
        end
        MODE_BCAST: begin
          wmask = en;
          err_n = ~|en;
        end
        MODE_SCAN: begin
          wmask = found ? sel_oh ^ sel_oh | (NCH'(1) << idx) : '0;
          err_n = ~found;
          ptr_n = found ? (int'(idx) == NCH - 1 ? '0 : idx + 1'b1) : ptr;
        end
        default: begin
          wmask = en;
          wval = '0;
          ptr_n = '0;
        end
      endcase
  end

  // channel registers hold until written; strobes and pointer update with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
      out_vld <= '0;
      ptr <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (wmask[i]) ch[i] <= wval;
      out_vld <= wmask;
      ptr <= ptr_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_chan_router.sv
// tb_chan_router: table-driven scoreboard bench for chan_router (NCH=4 and NCH=3)
module tb_chan_router;
  import chan_router_pkg::*;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [3:0]  en = 0, data = 0;
  logic [1:0]  sel = 0, mode = 0;
  logic        wr = 0;
  logic [15:0] out;
  logic [3:0]  out_vld;
  logic [1:0]  ptr;
  logic        err;

  logic [2:0]  en3 = 0;
  logic [1:0]  sel3 = 0, mode3 = 0;
  logic [3:0]  data3 = 0;
  logic        wr3 = 0;
  logic [11:0] out3;
  logic [2:0]  vld3;
  logic [1:0]  ptr3;
  logic        err3;

  chan_router #(.NCH(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .data(data), .wr(wr), .mode(mode),
    .out(out), .out_vld(out_vld), .ptr(ptr), .err(err)
  );

  chan_router #(.NCH(3), .DW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .sel(sel3), .data(data3), .wr(wr3), .mode(mode3),
    .out(out3), .out_vld(vld3), .ptr(ptr3), .err(err3)
  );

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic        wr;
    logic [1:0]  mode;
    logic [15:0] out;
    logic [3:0]  vld;
    logic [1:0]  ptr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  vld;
    logic [1:0]  ptr;
    logic        err;
  } exp_t;

  localparam int NV = 19;
  vec_t v[NV];
  exp_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input int i);
    exp_t e;
    e = q.pop_front();
    chk($sformatf("v%0d out", i), 32'(out), 32'(e.out));
    chk($sformatf("v%0d out_vld", i), 32'(out_vld), 32'(e.vld));
    chk($sformatf("v%0d ptr", i), 32'(ptr), 32'(e.ptr));
    chk($sformatf("v%0d err", i), 32'(err), 32'(e.err));
  endtask

  task automatic drive3(input logic [2:0] e, input logic [1:0] s, input logic [3:0] d, input logic [1:0] m);
    en3 = e; sel3 = s; data3 = d; mode3 = m; wr3 = 1;
    @(negedge clk);
    wr3 = 0;
  endtask

  initial begin
    v[0]  = '{4'hF, 2'd1, 4'h1, 1, MODE_ADDR,  16'h0010, 4'b0010, 2'd0, 0};
    v[1]  = '{4'hB, 2'd2, 4'h9, 1, MODE_ADDR,  16'h0010, 4'b0000, 2'd0, 1};
    v[2]  = '{4'hF, 2'd3, 4'hA, 1, MODE_ADDR,  16'hA010, 4'b1000, 2'd0, 0};
    v[3]  = '{4'hF, 2'd0, 4'hF, 0, MODE_BCAST, 16'hA010, 4'b0000, 2'd0, 0};
    v[4]  = '{4'hA, 2'd0, 4'h5, 1, MODE_BCAST, 16'h5050, 4'b1010, 2'd0, 0};
    v[5]  = '{4'h0, 2'd0, 4'h6, 1, MODE_BCAST, 16'h5050, 4'b0000, 2'd0, 1};
    v[6]  = '{4'h9, 2'd3, 4'h6, 1, MODE_SCAN,  16'h5056, 4'b0001, 2'd1, 0};
    v[7]  = '{4'h9, 2'd0, 4'h7, 1, MODE_SCAN,  16'h7056, 4'b1000, 2'd0, 0};
    v[8]  = '{4'h9, 2'd2, 4'h8, 1, MODE_SCAN,  16'h7058, 4'b0001, 2'd1, 0};
    v[9]  = '{4'h0, 2'd0, 4'h9, 1, MODE_SCAN,  16'h7058, 4'b0000, 2'd1, 1};
    v[10] = '{4'h4, 2'd0, 4'h3, 1, MODE_SCAN,  16'h7358, 4'b0100, 2'd3, 0};
    v[11] = '{4'h1, 2'd0, 4'h4, 1, MODE_SCAN,  16'h7354, 4'b0001, 2'd1, 0};
    v[12] = '{4'hE, 2'd0, 4'hC, 1, MODE_ADDR,  16'h7354, 4'b0000, 2'd1, 1};
    v[13] = '{4'h6, 2'd0, 4'h9, 1, MODE_CLEAR, 16'h7004, 4'b0110, 2'd0, 0};
    v[14] = '{4'hF, 2'd0, 4'h2, 1, MODE_SCAN,  16'h7002, 4'b0001, 2'd1, 0};
    v[15] = '{4'h0, 2'd0, 4'h2, 1, MODE_CLEAR, 16'h7002, 4'b0000, 2'd0, 0};
    v[16] = '{4'hF, 2'd0, 4'h2, 1, MODE_CLEAR, 16'h0000, 4'b1111, 2'd0, 0};
    v[17] = '{4'hF, 2'd2, 4'hE, 1, MODE_BCAST, 16'hEEEE, 4'b1111, 2'd0, 0};
    v[18] = '{4'hF, 2'd0, 4'h1, 0, MODE_CLEAR, 16'hEEEE, 4'b0000, 2'd0, 0};

    #2;
    chk("rst out", 32'(out), 0);
    chk("rst ptr", 32'(ptr), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("idle out", 32'(out), 0);
    chk("idle out_vld", 32'(out_vld), 0);
    chk("idle ptr", 32'(ptr), 0);
    chk("idle err", 32'(err), 0);

    for (int i = 0; i < NV; i++) begin
      en = v[i].en; sel = v[i].sel; data = v[i].data; wr = v[i].wr; mode = v[i].mode;
      q.push_back('{v[i].out, v[i].vld, v[i].ptr, v[i].err});
      @(negedge clk);
      check_pop(i);
    end
    chk("queue drained", 32'(q.size()), 0);

    en = 4'hF; mode = MODE_SCAN; data = 4'h1; wr = 1;
    @(negedge clk);
    chk("burst ptr", 32'(ptr), 1);
    data = 4'h2;
    #2 rst_n = 0;
    #1;
    chk("async rst out", 32'(out), 0);
    chk("async rst ptr", 32'(ptr), 0);
    chk("async rst out_vld", 32'(out_vld), 0);
    chk("async rst err", 32'(err), 0);
    @(negedge clk);
    chk("held rst out", 32'(out), 0);
    wr = 0;
    rst_n = 1;
    @(negedge clk);
    chk("post rst out", 32'(out), 0);
    chk("post rst ptr", 32'(ptr), 0);

    drive3(3'b111, 2'd3, 4'h7, MODE_ADDR);
    chk("n3 sel3 err", 32'(err3), 1);
    chk("n3 sel3 out", 32'(out3), 0);
    drive3(3'b010, 2'd0, 4'h1, MODE_SCAN);
    chk("n3 scan1 ptr", 32'(ptr3), 2);
    drive3(3'b001, 2'd0, 4'h5, MODE_SCAN);
    chk("n3 wrap out", 32'(out3), 32'h015);
    chk("n3 wrap ptr", 32'(ptr3), 1);
    chk("n3 wrap vld", 32'(vld3), 1);
    drive3(3'b100, 2'd0, 4'h9, MODE_SCAN);
    chk("n3 last out", 32'(out3), 32'h915);
    chk("n3 last ptr", 32'(ptr3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/chan_router.md
# chan_router

Registered, parametrised N-channel data router with per-channel enables, an addressed mode, a broadcast mode, an auto-scan mode and a clear mode. It replaces the fixed 4-channel combinational select/route block. Each output channel holds its last written word until it is overwritten or cleared, and raises a one-cycle update strobe when it changes. It sits between a single data source and NCH downstream consumers.

## Interface
- NCH, 4, number of output channels (2..16)
- DW, 4, data width per channel
- SELW, $clog2(NCH), select/pointer width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  NCH  per-channel enable; bit i gates all writes to channel i
- sel  in  SELW  target channel in addressed mode
- data  in  DW  write data
- wr  in  1  write strobe, sampled on rising edge
- mode  in  2  0 ADDR, 1 BCAST, 2 SCAN, 3 CLEAR
- out  out  NCH*DW  channel i occupies bits [i*DW +: DW]
- out_vld  out  NCH  one-cycle pulse per channel updated this edge
- ptr  out  SELW  auto-scan pointer
- err  out  1  one-cycle pulse on a rejected write

## Operation
- No action when wr=0: out holds; out_vld, err are 0.
- mode and en are sampled together with wr on the same edge.
- ADDR:
  - If sel < NCH and en[sel]=1: out[sel] <= data and out_vld[sel]=1.
  - Otherwise: no write and err=1.
- BCAST:
  - Every channel i with en[i]=1 gets data, and its out_vld[i]=1.
  - If en is all zeros: err=1, no write.
- SCAN:
  - target = first i with en[i]=1, searching ptr, ptr+1, … with wrap mod NCH.
  - out[target] <= data, out_vld[target]=1, ptr <= (target+1) mod NCH.
  - If en is all zeros: err=1, ptr unchanged.
- CLEAR:
  - All channels with en[i]=1 are set to 0, with out_vld[i]=1.
  - ptr <= 0 regardless of en. err is never raised in this mode.
- ptr changes only on a SCAN write or a CLEAR.
- A disabled channel is never modified in any mode.
- sel is ignored outside ADDR.

## Timing
- Reset (async assert, sync to clk edge on release):
  - out = 0 for all channels.
  - out_vld = 0, ptr = 0, err = 0.
- Latency is one cycle: out, out_vld, ptr and err are all registered and change on the edge that samples wr=1.
- out_vld and err are pulses: high exactly one cycle per accepted/rejected wr.
- Back-to-back wr on consecutive cycles is fully supported; each is independent, and SCAN advances ptr every cycle.
- Wrap: SCAN with ptr=NCH-1 and only en[0]=1 writes channel 0 and sets ptr to 1.
- ptr is always < NCH. When NCH is not a power of two, the increment wraps explicitly at NCH.
- Reset asserted mid-operation: all state clears immediately and a pending wr is discarded.
- en changing in the same cycle as wr: the new en value applies.

## Structure
- Package chan_router_pkg:
  - mode constants MODE_ADDR=2'd0, MODE_BCAST=2'd1, MODE_SCAN=2'd2, MODE_CLEAR=2'd3.
  - a mode_t typedef.
- Sub-module rr_find_next:
  - parameters NCH, SELW.
  - inputs: mask[NCH], start[SELW].
  - outputs: idx[SELW], found.
  - purely combinational wrap-around priority search, used by SCAN.
- The top level holds the NCH×DW channel register array, the ptr register and the strobe registers.

## Test plan
- Reset then idle: after rst_n release with wr=0 for 10 cycles, out=0, out_vld=0, ptr=0, err=0.
- ADDR, NCH=4, DW=4, en=4'b1111: sel=1, data=4'h1, wr=1 → next cycle out[1]=1, out_vld=4'b0010. Then sel=2 with en[2]=0 → err=1 and out unchanged.
- BCAST, en=4'b1010, data=4'h5 → out[1]=out[3]=5, out[0] and out[2] unchanged, out_vld=4'b1010. Then en=0 → err=1.
- SCAN, en=4'b1001, ptr=0, data 6,7,8 on consecutive cycles:
  - out[0]=6, then out[3]=7, then out[0]=8.
  - ptr sequence 1, 0, 1.
  - one out_vld pulse per cycle.
- CLEAR after the above, en=4'b1111 → all out=0, out_vld=4'b1111, ptr=0. Also assert rst_n low mid-SCAN burst → all outputs 0 asynchronously.
- NCH=3 build: ADDR with sel=3 → err=1. SCAN from ptr=2 with en=3'b001 → writes channel 0, ptr=1.
